register_file_arbiter: RTL

//  Shares one single-port register_file (sel/wr/addr/wdata/rdata) between NREQ requesters.

---
 rtl/register_file_arbiter_pkg.sv | 29 ++
 rtl/register_file_arbiter_rr_arbiter.sv | 35 +++
 rtl/register_file_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/register_file_arbiter_pkg.sv
// Shared types and helpers for the register-file arbiter and its round-robin picker.
package register_file_arbiter_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int WIDTH1_DEF = 32;
    localparam int WIDTH2_DEF = 5;

    // Helpers are sized for the largest supported requester count (8).
    localparam int NREQ_MAX  = 8;
    localparam int IDX_W_MAX = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDX_W_MAX-1:0] idx);
        logic [NREQ_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next requester index with an explicit wrap, so non-power-of-2 counts work.
    function automatic int next_index(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/register_file_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module register_file_arbiter_rr_arbiter
    import register_file_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [PW-1:0]   ptr_i,
    output logic            any_o,
    output logic [PW-1:0]   grant_idx_o,
    output logic [NREQ-1:0] grant_oh_o
);

    // Walk the requesters starting one past the pointer; first hit wins.
    always_comb begin
        logic [PW-1:0] cand;
        logic          found;
        any_o       = 1'b0;
        grant_idx_o = '0;
        grant_oh_o  = '0;
        found       = 1'b0;
        cand        = PW'(next_index(int'(ptr_i), NREQ));
        for (int k = 0; k < NREQ; k++) begin
            if (!found && eligible_i[cand]) begin
                found       = 1'b1;
                grant_idx_o = cand;
            end
            cand = PW'(next_index(int'(cand), NREQ));
        end
        any_o      = found;
        grant_oh_o = found ? NREQ'(onehot(IDX_W_MAX'(grant_idx_o))) : '0;
    end

endmodule

// File: rtl/register_file_arbiter.sv
// Shares one single-port register file between NREQ requesters, one access per cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access driven; rf_sel low, waiting for any req_valid
// ACCESS | latched command of winner g on the rf port, req_ready[g] high
module register_file_arbiter
    import register_file_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int WIDTH1 = WIDTH1_DEF,
    parameter int WIDTH2 = WIDTH2_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*WIDTH2-1:0]   req_addr,
    input  logic [NREQ*WIDTH1-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [WIDTH1-1:0]        rsp_rdata,
    output logic                     rf_sel,
    output logic                     rf_wr,
    output logic [WIDTH2-1:0]        rf_addr,
    output logic [WIDTH1-1:0]        rf_wdata,
    input  logic [WIDTH1-1:0]        rf_rdata
);

    localparam int PW = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     g_q, g_d;
    logic              wr_q, wr_d;
    logic [WIDTH2-1:0] addr_q, addr_d;
    logic [WIDTH1-1:0] wdata_q, wdata_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH1-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]   cur_oh;
    logic [NREQ-1:0]   eligible;
    logic              win_any;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   win_oh;

    // The requester being served still holds valid during its ready cycle; mask it.
    assign cur_oh   = NREQ'(onehot(IDX_W_MAX'(g_q)));
    assign eligible = (state_q == ACCESS) ? (req_valid & ~cur_oh) : req_valid;

    register_file_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .any_o       (win_any),
        .grant_idx_o (win_idx),
        .grant_oh_o  (win_oh)
    );

    // Next state: pick a winner, latch its command, and capture read data of the current access.
    always_comb begin
        state_d     = IDLE;
        ptr_d       = ptr_q;
        g_d         = g_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!wr_q) begin
                    rsp_valid_d = cur_oh;
                    rsp_rdata_d = rf_rdata;
                end
                if (win_any) begin
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
        if (win_any) begin
            ptr_d   = win_idx;
            g_d     = win_idx;
            wr_d    = req_wr[win_idx];
            addr_d  = req_addr[int'(win_idx)*WIDTH2 +: WIDTH2];
            wdata_d = req_wdata[int'(win_idx)*WIDTH1 +: WIDTH1];
            ready_d = win_oh;
        end
    end

    // State, command latch, pointer and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(NREQ - 1);
            g_q         <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rf_sel    = (state_q == ACCESS);
    assign rf_wr     = rf_sel & wr_q;
    assign rf_addr   = addr_q;
    assign rf_wdata  = wdata_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
